// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RISC-V core types and constants used by the load/store unit
package riscv_pkg;
  typedef enum logic [2:0] {
    BYTE       = 3'd0,
    HWORD      = 3'd1,
    WORD       = 3'd2,
    DWORD      = 3'd3,
    QWORD      = 3'd4,
    UNDEF_SIZE = 3'd7
  } biu_size_t;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;
  localparam logic [2:0] SD  = 3'b011;
  localparam int EXCEPTION_SIZE         = 16;
  localparam int CAUSE_MISALIGNED_LOAD  = 4;
  localparam int CAUSE_MISALIGNED_STORE = 6;
  typedef struct packed {
    logic       is_load;
    logic [2:0] func3;
    logic [2:0] offset;
  } lsu_qentry_t;
endpackage

// File: rtl/riscv_lsu_queue.sv
// riscv_lsu_queue: in-order metadata FIFO for outstanding LSU accesses
module riscv_lsu_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        push,
  input  logic        pop,
  input  lsu_qentry_t din,
  output lsu_qentry_t dout,
  output logic        full,
  output logic        empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wp_q, wp_d, rp_q, rp_d;
  lsu_qentry_t mem_q [DEPTH];
  lsu_qentry_t mem_d [DEPTH];
  logic push_ok, pop_ok;
  assign empty = wp_q == rp_q;
  assign full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign dout  = mem_q[rp_q[AW-1:0]];
  // Pointer advance and slot write; a full queue still accepts a push when it pops
  always_comb begin
    pop_ok  = pop && !empty;
    push_ok = push && (!full || pop_ok);
    wp_d    = wp_q + (AW+1)'(push_ok);
    rp_d    = rp_q + (AW+1)'(pop_ok);
    mem_d   = mem_q;
    if (push_ok) mem_d[wp_q[AW-1:0]] = din;
  end
  // Pointer registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end
  // Entry storage needs no reset; pointers define validity
  always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: rtl/riscv_lsu_q.sv
// riscv_lsu_q: pipelined LSU with up to DEPTH in-order outstanding accesses; RISCV_LSU_MISALIGN_CHK_EN traps misaligned accesses locally
module riscv_lsu_q
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      ex_stall,
  input  logic                      flush,
  input  logic                      id_bubble,
  input  logic [31:0]               id_instr,
  input  logic [EXCEPTION_SIZE-1:0] id_exception,
  input  logic [XLEN-1:0]           opA,
  input  logic [XLEN-1:0]           opB,
  output logic                      lsu_stall,
  output logic                      lsu_bubble,
  output logic [EXCEPTION_SIZE-1:0] lsu_exception,
  output logic [XLEN-1:0]           lsu_r,
  output logic                      lsu_r_valid,
  output logic                      lsu_r_err,
  output logic                      dmem_req,
  output logic [XLEN-1:0]           dmem_adr,
  output logic [XLEN-1:0]           dmem_d,
  output logic                      dmem_we,
  output biu_size_t                 dmem_size,
  input  logic                      dmem_gnt,
  input  logic                      dmem_ack,
  input  logic [XLEN-1:0]           dmem_q,
  input  logic                      dmem_err
);
  localparam int OFF = $clog2(XLEN/8);
  localparam int OW  = $clog2(DEPTH+1);
  logic [6:0] opcode;
  logic [2:0] func3;
  logic is_load, is_store, memop, accept, issue, mis, pop, q_full, q_empty;
  logic [XLEN-1:0] imm_s, adr, sh;
  logic [6:0] ld_n;
  biu_size_t size;
  lsu_qentry_t push_e, head;
  logic [EXCEPTION_SIZE-1:0] mis_exc;
  logic [OW-1:0] occ_q, occ_d;
  logic dmem_req_q, dmem_req_d, dmem_we_q, dmem_we_d;
  logic [XLEN-1:0] dmem_adr_q, dmem_adr_d, dmem_d_q, dmem_d_d, lsu_r_q, lsu_r_d;
  biu_size_t dmem_size_q, dmem_size_d;
  logic lsu_r_valid_q, lsu_r_valid_d, lsu_r_err_q, lsu_r_err_d, lsu_bubble_q, lsu_bubble_d;
  logic [EXCEPTION_SIZE-1:0] lsu_exception_q, lsu_exception_d;
  logic unused_bits;
  function automatic logic [XLEN-1:0] ext(input logic [XLEN-1:0] v, input logic [6:0] n, input logic u);
    logic [XLEN-1:0] m;
    m = (XLEN'(1) << n) - XLEN'(1);
    return (v & m) | ((!u && v[n-1]) ? ~m : '0);
  endfunction
  // Decode the ID/EX operands and decide whether this cycle's memop is taken and issued
  always_comb begin
    opcode   = id_instr[6:0];
    func3    = id_instr[14:12];
    is_load  = opcode == OPC_LOAD;
    is_store = opcode == OPC_STORE;
    imm_s    = {{(XLEN-12){id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
    adr      = opA + (is_store ? imm_s : opB);
    size     = (func3 == 3'b111 || (is_store && func3[2])) ? UNDEF_SIZE :
               func3[1:0] == 2'b00 ? BYTE :
               func3[1:0] == 2'b01 ? HWORD :
               func3[1:0] == 2'b10 ? ((func3[2] && XLEN != 64) ? UNDEF_SIZE : WORD) :
               (XLEN == 64 ? DWORD : UNDEF_SIZE);
`ifdef RISCV_LSU_MISALIGN_CHK_EN
    mis      = (size == HWORD && adr[0]) || (size == WORD && |adr[1:0]) || (size == DWORD && |adr[2:0]);
`else
    mis      = 1'b0;
`endif
    memop    = !id_bubble && (is_load || is_store) && !(|id_exception) && !flush && !ex_stall;
    pop      = dmem_ack && !q_empty;
    accept   = memop && !(dmem_req_q && !dmem_gnt) && (occ_q < OW'(DEPTH) || dmem_ack);
    issue    = accept && !mis;
    push_e   = {is_load, func3, 3'(adr[OFF-1:0])};
  end
  // Next state of the request, response and pipeline status registers
  always_comb begin
    sh              = dmem_q >> {head.offset, 3'b000};
    ld_n            = head.func3[1:0] == 2'b00 ? 7'd8 : head.func3[1:0] == 2'b01 ? 7'd16 :
                      head.func3[1:0] == 2'b10 ? 7'd32 : 7'(XLEN);
    mis_exc         = '0;
    mis_exc[CAUSE_MISALIGNED_LOAD]  = accept && mis && is_load;
    mis_exc[CAUSE_MISALIGNED_STORE] = accept && mis && is_store;
    occ_d           = occ_q + OW'(issue) - OW'(pop);
    dmem_req_d      = issue || (dmem_req_q && !dmem_gnt);
    dmem_adr_d      = issue ? adr : dmem_adr_q;
    dmem_d_d        = issue ? opB << {adr[OFF-1:0], 3'b000} : dmem_d_q;
    dmem_we_d       = issue ? is_store : dmem_we_q;
    dmem_size_d     = issue ? size : dmem_size_q;
    lsu_r_d         = (pop && head.is_load) ? ext(sh, ld_n, head.func3[2]) : lsu_r_q;
    lsu_r_valid_d   = pop && head.is_load;
    lsu_r_err_d     = pop && dmem_err;
    lsu_bubble_d    = ex_stall ? lsu_bubble_q : !accept;
    lsu_exception_d = ex_stall ? lsu_exception_q : id_exception | mis_exc;
  end
  // State registers; reset discards every outstanding access
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      occ_q           <= '0;
      dmem_req_q      <= 1'b0;
      dmem_adr_q      <= '0;
      dmem_d_q        <= '0;
      dmem_we_q       <= 1'b0;
      dmem_size_q     <= UNDEF_SIZE;
      lsu_r_q         <= '0;
      lsu_r_valid_q   <= 1'b0;
      lsu_r_err_q     <= 1'b0;
      lsu_bubble_q    <= 1'b1;
      lsu_exception_q <= '0;
    end else begin
      occ_q           <= occ_d;
      dmem_req_q      <= dmem_req_d;
      dmem_adr_q      <= dmem_adr_d;
      dmem_d_q        <= dmem_d_d;
      dmem_we_q       <= dmem_we_d;
      dmem_size_q     <= dmem_size_d;
      lsu_r_q         <= lsu_r_d;
      lsu_r_valid_q   <= lsu_r_valid_d;
      lsu_r_err_q     <= lsu_r_err_d;
      lsu_bubble_q    <= lsu_bubble_d;
      lsu_exception_q <= lsu_exception_d;
    end
  end
  riscv_lsu_queue #(.DEPTH(DEPTH)) u_queue (
    .clk   (clk),
    .rstn  (rstn),
    .push  (issue),
    .pop   (pop),
    .din   (push_e),
    .dout  (head),
    .full  (q_full),
    .empty (q_empty)
  );
  assign lsu_stall     = memop && !accept;
  assign lsu_bubble    = lsu_bubble_q;
  assign lsu_exception = lsu_exception_q;
  assign lsu_r         = lsu_r_q;
  assign lsu_r_valid   = lsu_r_valid_q;
  assign lsu_r_err     = lsu_r_err_q;
  assign dmem_req      = dmem_req_q;
  assign dmem_adr      = dmem_adr_q;
  assign dmem_d        = dmem_d_q;
  assign dmem_we       = dmem_we_q;
  assign dmem_size     = dmem_size_q;
  assign unused_bits   = ^{id_instr[24:15], q_full};
  // A response with nothing outstanding is a BIU protocol error and is dropped
  assert property (@(posedge clk) disable iff (!rstn) !(dmem_ack && q_empty));
endmodule

// File: doc/riscv_lsu_q.md
# riscv_lsu_q

Pipelined load/store unit for the RISC-V core with up to DEPTH outstanding data-memory transactions, replacing the single-request LSU. It sits between the ID/EX operand path and the BIU data port. It issues loads and stores with a request/grant handshake and tracks in-order responses in a metadata queue. Load data is aligned and sign- or zero-extended before it is returned to writeback.

## Interface
- XLEN, 32: data/address width, 32 or 64
- DEPTH, 4: maximum accepted-but-unanswered accesses, power of 2, at least 2
- clk  in  1  core clock
- rstn  in  1  asynchronous active-low reset
- ex_stall  in  1  pipeline stall; blocks acceptance
- flush  in  1  exception in EX/MEM/WB; blocks acceptance this cycle
- id_bubble  in  1  instruction slot empty
- id_instr  in  32  instruction
- id_exception  in  EXCEPTION_SIZE  upstream exception bits
- opA, opB  in  XLEN  rs1, rs2/immI operands
- lsu_stall  out  1  memory op presented but not accepted
- lsu_bubble  out  1  no memory op accepted last cycle
- lsu_exception  out  EXCEPTION_SIZE  registered exception bits
- lsu_r  out  XLEN  aligned, extended load data
- lsu_r_valid  out  1  lsu_r valid, one-cycle pulse
- lsu_r_err  out  1  bus error on that response
- dmem_req  out  1  request valid
- dmem_adr, dmem_d  out  XLEN  address, lane-shifted store data
- dmem_we  out  1  store
- dmem_size  out  biu_size_t  access size
- dmem_gnt  in  1  request accepted by BIU
- dmem_ack  in  1  in-order response
- dmem_q  in  XLEN  response data
- dmem_err  in  1  response error

## Operation
- A memop is `!id_bubble & opcode∈{OPC_LOAD,OPC_STORE} & ~|id_exception & !flush & !ex_stall`.
- The address is opA+opB for loads and opA+immS for stores. Size decode is from func3. LD/SD/LWU are only legal when XLEN==64; otherwise size is UNDEF_SIZE.
- occ counter, 0..DEPTH: +1 on accept, −1 on dmem_ack, both in the same cycle gives net 0.
- Accept condition: memop & !(dmem_req & !dmem_gnt) & (occ<DEPTH | dmem_ack).
- lsu_stall is combinational and equals memop & !accept.
- On accept:
  - Register dmem_adr/d/we/size and set dmem_req.
  - Push {is_load, func3, adr[log2(XLEN/8)-1:0]} into the queue.
- dmem_req and its payload stay stable until dmem_gnt. dmem_req drops the cycle after a grant unless a new accept happens in that same cycle, so back-to-back issue is allowed.
- On dmem_ack the queue pops.
  - Load entry: shift dmem_q right by 8·offset, then sign- or zero-extend per func3. Register the result onto lsu_r, lsu_r_valid=1, lsu_r_err=dmem_err.
  - Store entry: lsu_r_valid stays 0. lsu_r_err pulses if dmem_err.
- dmem_ack with occ==0 is a protocol error. It is ignored and asserted in simulation.
- flush never cancels requests already issued. They complete and their responses are still returned.
- lsu_bubble is registered: 0 if accept, else 1. It holds while ex_stall.
- lsu_exception is registered: id_exception when !ex_stall, plus misaligned bits (see Configuration).
- Reset values: lsu_stall 0 (combinational), lsu_bubble 1, lsu_exception 0, lsu_r 0, lsu_r_valid 0, lsu_r_err 0, dmem_req 0, dmem_we 0, dmem_adr 0, dmem_d 0, dmem_size UNDEF_SIZE. occ and the queue pointers reset to 0.
- Reset mid-transaction drops all queue state. The BIU is reset by the same rstn.

## Timing
- Accept in cycle N → dmem_req high in N+1.
- Earliest ack is in the grant cycle (N+1) → lsu_r_valid in N+2.
- Full throughput: one access per cycle when gnt and ack are continuous and occ<DEPTH.
- At occ==DEPTH, a simultaneous ack and accept is permitted and occ stays at DEPTH.

## Configuration
- RISCV_LSU_MISALIGN_CHK_EN defined:
  - Misaligned accesses are not issued and not pushed. These are halfword at an odd address, word not 4-aligned, and dword not 8-aligned.
  - The next cycle, lsu_exception sets CAUSE_MISALIGNED_LOAD or CAUSE_MISALIGNED_STORE and lsu_bubble=0.
- Undefined: every access is issued. Alignment faults come from the BIU.

## Structure
- riscv_pkg holds biu_size_t, OPC_LOAD/OPC_STORE, the LB..SD patterns, EXCEPTION_SIZE and the CAUSE_* indices. Add lsu_qentry_t there.
- Sub-module riscv_lsu_queue: synchronous FIFO of lsu_qentry_t with parameter DEPTH, push/pop/full/empty, same-cycle push and pop allowed when full.

## Test plan
- LW at 0x100, gnt+ack in the same cycle, dmem_q=0x8000_00F0 → lsu_r=0x8000_00F0, valid 2 cycles after accept.
- LB at 0x103, dmem_q=0x80xx_xxxx → lsu_r=0xFFFF_FF80. Same access as LBU → 0x0000_0080.
- SH at 0x102 with opB=0x1234 → dmem_d=0x1234_0000, dmem_size=HWORD, dmem_we=1, no lsu_r_valid.
- DEPTH=4, gnt tied 1, ack held 0, five loads presented → fifth gets lsu_stall=1. One ack releases it in the same cycle.
- gnt low for 3 cycles → dmem_req/adr stable throughout. flush during the wait → request still completes and lsu_r_valid is still returned.
- With the macro defined, LW at 0x102 → no dmem_req, lsu_exception has CAUSE_MISALIGNED_LOAD set. Without the macro, the request is issued.
